// File: rtl/servo_pwm_pkg.sv
// Shared constants for the servo PWM controller: register map, bit positions,
// default parameter values and the pulse-width clamp helper.
package servo_pwm_pkg;

  // Default timing: 50 MHz clock, 20 ms frame, 1 ms .. 2 ms pulse.
  localparam int DEF_PERIOD_CYCLES = 1_000_000;
  localparam int DEF_MIN_PULSE     = 50_000;
  localparam int DEF_MAX_PULSE     = 100_000;
  localparam int DEF_CNT_W         = 20;

  // Avalon-MM word addresses.
  localparam logic [2:0] ADDR_TARGET = 3'd0;
  localparam logic [2:0] ADDR_STEP   = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_CUR    = 3'd4;

  // Bit positions inside CTRL and STATUS.
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int STATUS_BUSY_BIT = 0;

  // Clamp on the full bus width so large writes saturate instead of
  // aliasing after truncation to the counter width.
  function automatic logic [31:0] clamp_u32(input logic [31:0] value,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    logic [31:0] result;
    result = value;
    if (value < lo) begin
      result = lo;
    end else if (value > hi) begin
      result = hi;
    end
    return result;
  endfunction

endpackage

// File: rtl/servo_pwm_frame.sv
// Frame counter and pulse comparator. The counter runs 0..PERIOD_CYCLES-1
// while enabled and is parked at 0 otherwise; pwm_out is the registered
// comparison of the count against the applied width.
module servo_pwm_frame
  import servo_pwm_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,       // current enable register
  input  logic             enable_next,  // value enable takes at this edge
  input  logic [CNT_W-1:0] width,        // applied pulse width (cur)
  output logic             boundary,     // last cycle of the frame
  output logic             pwm_out
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // The boundary cycle is where the slew logic may change the width.
  assign boundary = enable && (count == LAST_COUNT);

  // Frame counter: wraps at the end of the frame, parked at 0 when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Registered pulse; gating with enable_next drops the output on the same
  // edge that clears enable, so pwm_out is never high while enable is 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= enable && enable_next && (count < width);
    end
  end

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Avalon-MM servo PWM controller: register file, slew limiter that moves the
// applied width toward the target once per frame, and the frame generator.
module servo_pwm_ctrl
  import servo_pwm_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int MIN_PULSE     = DEF_MIN_PULSE,
  parameter int MAX_PULSE     = DEF_MAX_PULSE,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        pwm_out
);

  localparam logic [CNT_W-1:0] RESET_WIDTH = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] cur;
  logic             enable;
  logic             enable_next;
  logic             boundary;
  logic             busy;
  logic [31:0]      target_clamped;
  logic             unused_clamp_bits;
  logic             target_above;
  logic [CNT_W-1:0] distance;
  logic [CNT_W-1:0] cur_next;
  logic [31:0]      read_mux;

  // Clamped values always fit in CNT_W bits; the upper bits are dropped.
  assign target_clamped    = clamp_u32(avs_writedata, 32'(MIN_PULSE), 32'(MAX_PULSE));
  assign unused_clamp_bits = ^target_clamped[31:CNT_W];

  assign enable_next = (avs_write && (avs_address == ADDR_CTRL))
                       ? avs_writedata[CTRL_ENABLE_BIT] : enable;
  assign busy        = (cur != target);

  // Writable registers; STATUS, CUR and unmapped addresses ignore writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target <= RESET_WIDTH;
      step   <= '0;
      enable <= 1'b0;
    end else begin
      enable <= enable_next;
      if (avs_write) begin
        case (avs_address)
          ADDR_TARGET: target <= target_clamped[CNT_W-1:0];
          ADDR_STEP:   step   <= avs_writedata[CNT_W-1:0];
          default:     ;
        endcase
      end
    end
  end

  // Slew step: compare before subtracting so the distance never wraps, and
  // snap to target when no step limit applies or the target is within reach.
  always_comb begin
    target_above = (target > cur);
    distance     = target_above ? (target - cur) : (cur - target);
    cur_next     = target;
    if ((step != '0) && (distance > step)) begin
      cur_next = target_above ? (cur + step) : (cur - step);
    end
  end

  // Applied width changes only at a frame boundary, using the register
  // values from before any write landing on that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= RESET_WIDTH;
    end else if (boundary) begin
      cur <= cur_next;
    end
  end

  // Read multiplexer on pre-write register values; unmapped addresses read 0.
  always_comb begin
    read_mux = '0;
    case (avs_address)
      ADDR_TARGET: read_mux = 32'(target);
      ADDR_STEP:   read_mux = 32'(step);
      ADDR_CTRL:   read_mux[CTRL_ENABLE_BIT] = enable;
      ADDR_STATUS: read_mux[STATUS_BUSY_BIT] = busy;
      ADDR_CUR:    read_mux = 32'(cur);
      default:     read_mux = '0;
    endcase
  end

  // Registered read data, valid the cycle after the read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= read_mux;
    end else begin
      avs_readdata <= '0;
    end
  end

  servo_pwm_frame #(
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .CNT_W         (CNT_W)
  ) u_frame (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .enable_next (enable_next),
    .width       (cur),
    .boundary    (boundary),
    .pwm_out     (pwm_out)
  );

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Self-checking bench for servo_pwm_ctrl with timing scaled down by 1000
// (1000-cycle frame, 50..100 cycle pulses) so every scenario runs quickly.
module tb_servo_pwm_ctrl;

  localparam int P    = 1000;
  localparam int MINP = 50;
  localparam int MAXP = 100;
  localparam int W    = 20;
  localparam int MID  = (MINP + MAXP) / 2;

  localparam logic [2:0] A_TARGET = 3'd0;
  localparam logic [2:0] A_STEP   = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_CUR    = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        pwm_out;

  int checks = 0;
  int errors = 0;

  servo_pwm_ctrl #(
    .PERIOD_CYCLES (P),
    .MIN_PULSE     (MINP),
    .MAX_PULSE     (MAXP),
    .CNT_W         (W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .pwm_out       (pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  task automatic bus_read_write(input logic [2:0] addr, input logic [31:0] wdata,
                                output logic [31:0] data);
    @(negedge clk);
    avs_address   = addr;
    avs_writedata = wdata;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
    avs_read      = 1'b0;
    data          = avs_readdata;
  endtask

  // Leaves the bench on the first negedge sample of a new pulse.
  task automatic wait_rise();
    int n = 0;
    while (pwm_out !== 1'b0 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    while (pwm_out !== 1'b1 && n < 4 * P) begin
      @(negedge clk);
      n++;
    end
    if (pwm_out !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_rise: no pulse within %0d cycles, got pwm %b, expected 1", n, pwm_out);
    end
  endtask

  task automatic measure_high(output int hi);
    hi = 0;
    while (pwm_out === 1'b1 && hi < 2 * P) begin
      hi++;
      @(negedge clk);
    end
  endtask

  task automatic count_low(output int lo);
    lo = 0;
    while (pwm_out === 1'b0 && lo < 2 * P) begin
      lo++;
      @(negedge clk);
    end
  endtask

  task automatic count_highs(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
    end
  endtask

  function automatic int clamp_model(input logic [31:0] v);
    if (v < MINP) return MINP;
    if (v > MAXP) return MAXP;
    return int'(v);
  endfunction

  // One frame of slew toward the target, stated directly from the rules.
  function automatic int slew_model(input int c, input int t, input int s);
    if (s == 0) return t;
    if (t > c) return (t - c <= s) ? t : c + s;
    return (c - t <= s) ? t : c - s;
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] v;
    int hi, lo, s;
    int m_cur, m_target, m_step;

    reset = 1'b1;
    avs_address = '0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_read = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwm", pwm_out, 0);
    check("reset_readdata", avs_readdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset values of the register file.
    bus_read(A_TARGET, d); check("reset_target", d, MID);
    bus_read(A_STEP, d);   check("reset_step", d, 0);
    bus_read(A_CTRL, d);   check("reset_ctrl", d, 0);
    bus_read(A_STATUS, d); check("reset_status", d, 0);
    bus_read(A_CUR, d);    check("reset_cur", d, MID);

    // Register map, clamping and truncation, with output disabled.
    vecs[0]  = '{A_TARGET, 1'b1, 32'd10,          32'(MINP)};
    vecs[1]  = '{A_TARGET, 1'b1, 32'd200000,      32'(MAXP)};
    vecs[2]  = '{A_TARGET, 1'b1, 32'h0010_0032,   32'(MAXP)};
    vecs[3]  = '{A_TARGET, 1'b1, 32'hFFFF_FFFF,   32'(MAXP)};
    vecs[4]  = '{A_TARGET, 1'b1, 32'd75,          32'd75};
    vecs[5]  = '{A_TARGET, 1'b1, 32'd0,           32'(MINP)};
    vecs[6]  = '{A_STEP,   1'b1, 32'h0001_2345,   32'h0001_2345};
    vecs[7]  = '{A_STEP,   1'b1, 32'hFFF0_0007,   32'd7};
    vecs[8]  = '{A_CTRL,   1'b1, 32'd2,           32'd0};
    vecs[9]  = '{3'd5,     1'b1, 32'd123,         32'd0};
    vecs[10] = '{3'd7,     1'b0, 32'd0,           32'd0};
    vecs[11] = '{A_STATUS, 1'b1, 32'd0,           32'd1};
    vecs[12] = '{A_CUR,    1'b1, 32'd999,         32'(MID)};
    vecs[13] = '{A_TARGET, 1'b1, 32'd75,          32'd75};
    vecs[14] = '{A_STATUS, 1'b0, 32'd0,           32'd0};
    vecs[15] = '{A_STEP,   1'b1, 32'd0,           32'd0};
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, d);
      check($sformatf("table[%0d] addr %0d", i, vecs[i].addr), d, vecs[i].exp);
    end

    // Read and write to the same address return the old value.
    bus_read_write(A_TARGET, 32'd90, d); check("rw_same_old", d, 75);
    bus_read(A_TARGET, d);               check("rw_same_new", d, 90);
    bus_write(A_TARGET, 32'd75);

    // Enable: default width per frame and the frame length.
    bus_write(A_CTRL, 32'd1);
    wait_rise();
    measure_high(hi); check("t1_width", hi, MID);
    count_low(lo);    check("t1_low", lo, P - MID);
    measure_high(hi); check("t1_width2", hi, MID);

    // Slew limited ramp 75 -> 85 -> 95 -> 100.
    bus_write(A_STEP, 32'd10);
    bus_write(A_TARGET, 32'd100);
    wait_rise(); measure_high(hi); check("t3_width1", hi, 85);
    bus_read(A_STATUS, d); check("t3_busy1", d, 1);
    bus_read(A_CUR, d);    check("t3_cur1", d, 85);
    wait_rise(); measure_high(hi); check("t3_width2", hi, 95);
    bus_read(A_STATUS, d); check("t3_busy2", d, 1);
    wait_rise(); measure_high(hi); check("t3_width3", hi, 100);
    bus_read(A_STATUS, d); check("t3_busy3", d, 0);
    bus_read(A_CUR, d);    check("t3_cur3", d, 100);

    // TARGET written on the boundary cycle takes effect one frame later.
    bus_write(A_STEP, 32'd0);
    wait_rise();
    repeat (P - 3) @(negedge clk);
    bus_write(A_TARGET, 32'd50);
    wait_rise(); measure_high(hi); check("t4_same_frame", hi, 100);
    wait_rise(); measure_high(hi); check("t4_next_frame", hi, 50);

    // Randomized target/step writes against the frame-level model.
    m_cur = 50;
    m_target = 50;
    m_step = 0;
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        v = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 160));
        bus_write(A_TARGET, v);
        m_target = clamp_model(v);
      end
      if ($urandom_range(0, 2) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
        bus_write(A_STEP, 32'(s));
        m_step = s;
      end
      m_cur = slew_model(m_cur, m_target, m_step);
      wait_rise(); measure_high(hi);
      check($sformatf("rand[%0d] width", it), hi, m_cur);
      bus_read(A_CUR, d);    check($sformatf("rand[%0d] cur", it), d, m_cur);
      bus_read(A_TARGET, d); check($sformatf("rand[%0d] target", it), d, m_target);
      bus_read(A_STATUS, d); check($sformatf("rand[%0d] busy", it), d, 32'(m_cur != m_target));
    end

    // Disable mid-frame at count 30, then re-enable from count 0.
    bus_write(A_STEP, 32'd0);
    bus_write(A_TARGET, 32'd75);
    wait_rise();
    repeat (28) @(negedge clk);
    check("t5_high_before", pwm_out, 1);
    bus_write(A_CTRL, 32'd0);
    check("t5_low_next", pwm_out, 0);
    count_highs(P + 10, hi); check("t5_no_pulse", hi, 0);
    bus_read(A_CUR, d);      check("t5_cur_kept", d, 75);
    bus_write(A_CTRL, 32'd1);
    check("t5_low_at_enable", pwm_out, 0);
    @(negedge clk);
    check("t5_rise", pwm_out, 1);
    measure_high(hi); check("t5_width", hi, 75);

    // Reset mid-frame at count 40 with a 90-cycle pulse.
    bus_write(A_TARGET, 32'd90);
    wait_rise(); measure_high(hi); check("t6_width", hi, 90);
    wait_rise();
    repeat (39) @(negedge clk);
    check("t6_high_before", pwm_out, 1);
    reset = 1'b1;
    #1;
    check("t6_pwm_async", pwm_out, 0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_CUR, d);    check("t6_cur", d, MID);
    bus_read(A_TARGET, d); check("t6_target", d, MID);
    bus_read(A_CTRL, d);   check("t6_ctrl", d, 0);
    bus_read(A_STEP, d);   check("t6_step", d, 0);
    count_highs(P + 10, hi); check("t6_no_pulse", hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
